// File: rtl/int_acc_seq_if.sv
// rtl/int_acc_seq_if.sv - job control, sample and result handshake bundle for int_acc_seq
interface int_acc_seq_if #(
    parameter int IN_W  = 15,
    parameter int ACC_W = 20,
    parameter int CNT_W = 8
);
    logic             start;
    logic [CNT_W-1:0] len;
    logic             abort;
    logic             busy;
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_data;
    logic             out_ovf;

    modport master (
        output start, len, abort, in_valid, in_data, out_ready,
        input  busy, in_ready, out_valid, out_data, out_ovf
    );

    modport slave (
        input  start, len, abort, in_valid, in_data, out_ready,
        output busy, in_ready, out_valid, out_data, out_ovf
    );
endinterface

// File: rtl/int_acc_seq.sv
// rtl/int_acc_seq.sv - counted-job unsigned accumulator with valid/ready sample and result streams
// Optional feature: define INT_ACC_SAT_EN to saturate the accumulator on carry instead of wrapping.
module int_acc_seq #(
    parameter int IN_W  = 15,
    parameter int ACC_W = 20,
    parameter int CNT_W = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    int_acc_seq_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] len_q;
    logic             ovf;
    logic [ACC_W:0]   sum;
    logic             beat;
    logic             last_beat;

    assign beat      = bus.in_valid && (state == ACC);
    assign cnt_inc   = cnt + 1'b1;
    assign last_beat = beat && (cnt_inc == len_q);
    assign sum       = {1'b0, acc} + {{(ACC_W + 1 - IN_W){1'b0}}, bus.in_data};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (bus.abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state_nxt = (bus.len == '0) ? HOLD : ACC;
                    end
                end
                ACC: begin
                    if (last_beat) begin
                        state_nxt = HOLD;
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            cnt   <= '0;
            len_q <= '0;
            ovf   <= 1'b0;
        end else if (bus.abort) begin
            acc <= '0;
            cnt <= '0;
            ovf <= 1'b0;
        end else if (state == IDLE) begin
            if (bus.start) begin
                len_q <= bus.len;
                acc   <= '0;
                cnt   <= '0;
                ovf   <= 1'b0;
            end
        end else if (beat) begin
            cnt <= cnt_inc;
            if (sum[ACC_W]) begin
                ovf <= 1'b1;
`ifdef INT_ACC_SAT_EN
                // Once pinned at full scale every later add carries again, so it stays pinned.
                acc <= {ACC_W{1'b1}};
`else
                acc <= sum[ACC_W-1:0];
`endif
            end else begin
                acc <= sum[ACC_W-1:0];
            end
        end
    end

    // The accumulator itself is the result register; it only moves in ACC, so HOLD keeps it stable.
    assign bus.busy      = (state == ACC) || (state == HOLD);
    assign bus.in_ready  = (state == ACC);
    assign bus.out_valid = (state == HOLD);
    assign bus.out_data  = acc;
    assign bus.out_ovf   = ovf;
endmodule

// File: tb/tb_int_acc_seq.sv
// tb/tb_int_acc_seq.sv - scoreboard bench for int_acc_seq with randomized jobs and directed corner cases
module tb_int_acc_seq;
    localparam int ACC_W = 20;

    typedef struct packed {
        logic [ACC_W-1:0] data;
        logic             ovf;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_checks;
    int   n_fail;
    exp_t sbq [$];

    int_acc_seq_if bus ();

    int_acc_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input bit ok, input string name, input longint act, input longint exp);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: compares each accepted result against the scoreboard and checks hold stability.
    exp_t             mon_e;
    bit               holding;
    logic [ACC_W-1:0] held_data;
    logic             held_ovf;

    always @(negedge clk) begin
        if (!rst_n) begin
            holding = 1'b0;
        end else if (bus.out_valid && !bus.abort) begin
            if (holding) begin
                check(bus.out_data == held_data, "hold_stable_data", bus.out_data, held_data);
                check(bus.out_ovf == held_ovf, "hold_stable_ovf", bus.out_ovf, held_ovf);
            end
            if (bus.out_ready) begin
                if (sbq.size() == 0) begin
                    check(1'b0, "unexpected_output", bus.out_data, 0);
                end else begin
                    mon_e = sbq.pop_front();
                    check(bus.out_data == mon_e.data, "out_data", bus.out_data, mon_e.data);
                    check(bus.out_ovf == mon_e.ovf, "out_ovf", bus.out_ovf, mon_e.ovf);
                end
                holding = 1'b0;
            end else begin
                holding   = 1'b1;
                held_data = bus.out_data;
                held_ovf  = bus.out_ovf;
            end
        end else begin
            holding = 1'b0;
        end
    end

    // mode: 0 random, 1 i+1, 2 0x7FFF, 3 i+7; bub: 0 none, 1 alternate, 2 random 30%
    task automatic run_job(input int n, input int mode, input int bub, input int hold_low, input bit extra_start);
        logic [14:0] s [$];
        logic [14:0] v;
        longint      sum;
        exp_t        e;
        int          beats;
        int          guard;
        int          t0;
        bit          fire;
        sum = 0;
        for (int i = 0; i < n; i++) begin
            case (mode)
                0:       v = 15'($urandom);
                1:       v = 15'(i + 1);
                2:       v = 15'h7FFF;
                default: v = 15'(i + 7);
            endcase
            s.push_back(v);
            sum += longint'(v);
        end
        e.ovf = (sum >= 64'd1048576);
`ifdef INT_ACC_SAT_EN
        e.data = e.ovf ? 20'hFFFFF : 20'(sum);
`else
        e.data = 20'(sum);
`endif
        sbq.push_back(e);

        bus.start = 1'b1;
        bus.len   = 8'(n);
        @(posedge clk); #1;
        bus.start = 1'b0;
        t0 = cyc;
        if (n == 0) check(bus.in_ready == 1'b0, "len0_in_ready", bus.in_ready, 0);
        else        check(bus.in_ready == 1'b1, "acc_entry_in_ready", bus.in_ready, 1);

        beats = 0;
        guard = 0;
        while (beats < n && guard < 2000) begin
            case (bub)
                0:       bus.in_valid = 1'b1;
                1:       bus.in_valid = guard[0] == 1'b0;
                default: bus.in_valid = ($urandom_range(99) >= 30);
            endcase
            bus.in_data = bus.in_valid ? s[beats] : 15'($urandom);
            if (extra_start && beats == 1) begin
                bus.start = 1'b1;
                bus.len   = 8'd3;
            end
            fire = bus.in_valid && bus.in_ready;
            @(posedge clk); #1;
            bus.start = 1'b0;
            if (fire) beats++;
            guard++;
        end
        bus.in_valid = 1'b0;
        if (beats < n) check(1'b0, "beat_timeout", beats, n);

        guard = 0;
        while (!bus.out_valid && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        check(bus.out_valid == 1'b1, "out_valid_seen", bus.out_valid, 1);
        if (bub == 0) check(cyc - t0 + 1 == n + 1, "latency", cyc - t0 + 1, n + 1);

        repeat (hold_low) begin
            @(posedge clk); #1;
        end
        check(bus.out_valid == 1'b1, "valid_while_stalled", bus.out_valid, 1);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check(bus.busy == 1'b0 && bus.out_valid == 1'b0, "idle_after_accept", bus.busy, 0);
    endtask

    // Abort after 'after' beats; with in_hold the abort coincides with an output handshake.
    task automatic run_abort(input int n, input int after, input bit in_hold);
        bus.start = 1'b1;
        bus.len   = 8'(n);
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int i = 0; i < after; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 15'($urandom);
            @(posedge clk); #1;
        end
        bus.in_valid  = !in_hold;
        bus.in_data   = 15'($urandom);
        bus.out_ready = in_hold;
        bus.abort     = 1'b1;
        @(posedge clk); #1;
        bus.abort     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        check(bus.busy == 1'b0, "abort_busy", bus.busy, 0);
        check(bus.out_valid == 1'b0, "abort_out_valid", bus.out_valid, 0);
        check(bus.out_data == '0, "abort_cleared", bus.out_data, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: got %0d cycles expected completion", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        cyc           = 0;
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.len       = '0;
        bus.abort     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check(bus.busy == 1'b0, "reset_busy", bus.busy, 0);
        check(bus.in_ready == 1'b0, "reset_in_ready", bus.in_ready, 0);
        check(bus.out_valid == 1'b0, "reset_out_valid", bus.out_valid, 0);
        check(bus.out_data == '0, "reset_out_data", bus.out_data, 0);
        check(bus.out_ovf == 1'b0, "reset_out_ovf", bus.out_ovf, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_job(4, 1, 0, 0, 0);
        run_job(3, 2, 1, 3, 0);
        run_job(33, 2, 0, 0, 0);
        run_job(0, 0, 0, 1, 0);
        run_abort(5, 2, 0);
        run_job(2, 3, 0, 0, 0);
        run_abort(1, 1, 1);
        run_abort(2, 1, 0);
        run_job(6, 0, 0, 0, 1);

        // Asynchronous reset in the middle of a job, away from any clock edge.
        bus.start = 1'b1;
        bus.len   = 8'd10;
        @(posedge clk); #1;
        bus.start    = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = 15'h1234;
        repeat (3) begin
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check(bus.busy == 1'b0, "midjob_reset_busy", bus.busy, 0);
        check(bus.out_data == '0, "midjob_reset_out_data", bus.out_data, 0);
        check(bus.in_ready == 1'b0, "midjob_reset_in_ready", bus.in_ready, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int j = 0; j < 20; j++) begin
            run_job($urandom_range(40, 1), 0, 2, $urandom_range(3, 0), 0);
        end

        repeat (3) @(posedge clk);
        #1;
        check(sbq.size() == 0, "scoreboard_drained", sbq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
